mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multicycle control unit for the 16-bit RISC core. It decodes the opcode held in the instruction register and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives every datapath mux select (the 2:1 16-bit and 4:1 muxes), the register and PC write enables, and the memory request strobes. It sits directly upstream of the datapath muxes and produces their sel inputs.

Parameters:
OPCODE_W, 4, opcode width taken from ir_opcode (instr[15:12]).
MEM_TIMEOUT, 0, maximum cycles to wait for mem_ready; 0 disables the timeout.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ir_opcode  in  OPCODE_W  opcode field from the instruction register.
zero  in  1  ALU zero flag, used by BEQ.
mem_ready  in  1  memory done; sampled in every memory-wait state.
pc_we  out  1  PC write enable.
ir_we  out  1  instruction register load.
mem_re  out  1  memory read request.
mem_we  out  1  memory write request.
iord_sel  out  1  address mux select: 0 = PC, 1 = ALUOut.
alu_a_sel  out  1  ALU A mux select: 0 = PC, 1 = regA.
alu_b_sel  out  2  ALU B mux select: 0 = regB, 1 = const 1, 2 = sign-extended imm, 3 = zero-extended imm.
alu_op  out  2  ALU op: 0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
pc_src_sel  out  2  PC mux select: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
reg_we  out  1  register file write enable.
wb_sel  out  1  write-back data mux select: 0 = ALUOut, 1 = MDR.
reg_dst_sel  out  1  destination register select: 0 = rd field, 1 = rt field.
halted  out  1  FSM is in HALT.
mem_err  out  1  sticky flag: memory timeout occurred.

Behaviour:
- Opcode map: ADD=0, SUB=1, AND=2, OR=3, ADDI=4, LW=5, SW=6, BEQ=7, JMP=8, HLT=15. All other opcodes are illegal and are treated as a NOP, returning to FETCH.
- Moore machine. Every output is decoded from the state register only. Any output not listed for a state is 0.
- Reset: state = RST_IDLE, which drives all outputs 0. The wait counter clears and mem_err clears. RST_IDLE always goes to FETCH on the next clock.
- Reset asserted mid-operation aborts immediately, including during a memory wait. No write enable may glitch high during reset.
- FETCH outputs: mem_re=1, iord_sel=0, ir_we=mem_ready, alu_a_sel=0, alu_b_sel=1, alu_op=ADD, pc_src_sel=0, pc_we=mem_ready. FETCH stays while mem_ready=0 and goes to DECODE when mem_ready=1. Because ir_we and pc_we follow mem_ready, IR and PC update exactly once.
- DECODE outputs: alu_a_sel=0, alu_b_sel=2, alu_op=ADD (precomputes the branch target). Transitions by opcode:
  - R-type → EXEC_R.
  - ADDI → EXEC_I.
  - LW/SW → MEM_ADDR.
  - BEQ → BRANCH.
  - JMP → JUMP.
  - HLT → HALT.
  - illegal → FETCH.
- EXEC_R: alu_a_sel=1, alu_b_sel=0, alu_op=opcode[1:0]. Goes to ALU_WB.
- EXEC_I: alu_a_sel=1, alu_b_sel=2, ADD. Goes to ALU_WB.
- ALU_WB: reg_we=1, wb_sel=0. reg_dst_sel=1 for ADDI, 0 otherwise. Goes to FETCH.
- MEM_ADDR: alu_a_sel=1, alu_b_sel=2, ADD. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_re=1, iord_sel=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_we=1, wb_sel=1, reg_dst_sel=1. Goes to FETCH.
- MEM_WR: mem_we=1, iord_sel=1. Waits for mem_ready, then goes to FETCH.
- BRANCH: alu_a_sel=1, alu_b_sel=0, SUB, pc_src_sel=1, pc_we=zero. Goes to FETCH.
- JUMP: pc_src_sel=2, pc_we=1. Goes to FETCH.
- HALT: halted=1. Terminal; only reset exits it.
- Latency (cycles including FETCH, zero-wait memory):
  - R-type/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/JMP: 3.
- Wait counter: clears on entry to every wait state (FETCH, MEM_RD, MEM_WR) and increments each cycle that mem_ready=0. When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready still 0, the FSM goes to HALT and sets mem_err=1. The counter saturates; it never wraps.
- If mem_ready is high on the first cycle of a wait state, the FSM proceeds with zero wait. mem_ready outside wait states is ignored.

Decomposition:
- Shared package holds: opcode constants, state enum, ALU op encodings, and alu_b_sel/pc_src_sel encodings, for reuse by the datapath and the bench.
- Natural sub-module: mc_wait_counter, the timeout counter with clear/inc/expired outputs.

Test Plan:
- Reset, then release with mem_ready=1 → cycle 0 all outputs 0. Cycle 1 FETCH: mem_re=1, pc_we=1, ir_we=1.
- ADD (opcode 0), zero-wait memory → FETCH, DECODE, EXEC_R (alu_op=0, alu_b_sel=0), ALU_WB (reg_we=1, wb_sel=0, reg_dst_sel=0), back to FETCH; 4 cycles.
- LW with mem_ready low for 3 cycles in MEM_RD → mem_re=1 and iord_sel=1 held for 4 cycles, then MEM_WB with reg_we=1, wb_sel=1, reg_dst_sel=1, once only.
- BEQ with zero=1 and then zero=0 → BRANCH pc_we=1 with pc_src_sel=1 in the first case; pc_we=0 in the second.
- MEM_TIMEOUT=4, SW with mem_ready stuck 0 → HALT entered, halted=1, mem_err=1. Stays halted until rst_n pulse, after which mem_err=0.
- Opcode 9 (illegal) → DECODE then FETCH, with no reg_we, mem_we or pc_we in DECODE; rst_n asserted during MEM_WR → mem_we drops to 0 immediately (asynchronous).

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and
// the datapath mux select / ALU op codes used by both the datapath and the bench.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_JMP  = 4'd8,
    OP_HLT  = 4'd15
  } opcode_t;

  typedef enum logic [3:0] {
    ST_RST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_ALU_WB,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    ALUB_REGB = 2'd0,
    ALUB_ONE  = 2'd1,
    ALUB_SIMM = 2'd2,
    ALUB_ZIMM = 2'd3
  } alu_b_sel_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pc_src_sel_t;

  // States in which the FSM stalls on mem_ready and the wait counter runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory-wait timeout counter: cleared on entry to a wait state, counts stalled
// cycles, saturates, and flags expiry once MEM_TIMEOUT stalls have accumulated.
module mc_wait_counter #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero MEM_TIMEOUT means wait forever.
  assign expired = (MEM_TIMEOUT > 0) && (count >= CNT_LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 16-bit RISC core: sequences fetch/decode/
// execute/memory/writeback and drives every datapath select and write enable.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                ir_we,
  output logic                mem_re,
  output logic                mem_we,
  output logic                iord_sel,
  output logic                alu_a_sel,
  output logic [1:0]          alu_b_sel,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src_sel,
  output logic                reg_we,
  output logic                wb_sel,
  output logic                reg_dst_sel,
  output logic                halted,
  output logic                mem_err
);

  state_t     state;
  state_t     state_next;
  logic [3:0] op;
  logic       wait_inc;
  logic       wait_clear;
  logic       wait_expired;
  logic       timeout_hit;

  assign op          = 4'(ir_opcode);
  assign wait_inc    = is_wait_state(state) && !mem_ready;
  assign wait_clear  = is_wait_state(state_next) && (state_next != state);
  assign timeout_hit = wait_inc && wait_expired;

  mc_wait_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wait_clear),
    .inc    (wait_inc),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RST_IDLE;
      mem_err <= 1'b0;
    end else begin
      state <= state_next;
      if (timeout_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)         state_next = ST_DECODE;
        else if (wait_expired) state_next = ST_HALT;
      end
      ST_DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = ST_EXEC_R;
          OP_ADDI:                       state_next = ST_EXEC_I;
          OP_LW, OP_SW:                  state_next = ST_MEM_ADDR;
          OP_BEQ:                        state_next = ST_BRANCH;
          OP_JMP:                        state_next = ST_JUMP;
          OP_HLT:                        state_next = ST_HALT;
          default:                       state_next = ST_FETCH;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_next = ST_ALU_WB;
      ST_ALU_WB:   state_next = ST_FETCH;
      ST_MEM_ADDR: state_next = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (mem_ready)         state_next = ST_MEM_WB;
        else if (wait_expired) state_next = ST_HALT;
      end
      ST_MEM_WB: state_next = ST_FETCH;
      ST_MEM_WR: begin
        if (mem_ready)         state_next = ST_FETCH;
        else if (wait_expired) state_next = ST_HALT;
      end
      ST_BRANCH, ST_JUMP: state_next = ST_FETCH;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_RST_IDLE;
    endcase
  end

  // FETCH gates ir_we/pc_we with mem_ready so IR and PC load exactly once.
  always_comb begin
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    iord_sel    = 1'b0;
    alu_a_sel   = 1'b0;
    alu_b_sel   = ALUB_REGB;
    alu_op      = ALU_ADD;
    pc_src_sel  = PCSRC_ALU;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    reg_dst_sel = 1'b0;
    halted      = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_re    = 1'b1;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        alu_b_sel = ALUB_ONE;
      end
      ST_DECODE: alu_b_sel = ALUB_SIMM;
      ST_EXEC_R: begin
        alu_a_sel = 1'b1;
        alu_op    = op[1:0];
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_a_sel = 1'b1;
        alu_b_sel = ALUB_SIMM;
      end
      ST_ALU_WB: begin
        reg_we      = 1'b1;
        reg_dst_sel = (op == OP_ADDI);
      end
      ST_MEM_RD: begin
        mem_re   = 1'b1;
        iord_sel = 1'b1;
      end
      ST_MEM_WB: begin
        reg_we      = 1'b1;
        wb_sel      = 1'b1;
        reg_dst_sel = 1'b1;
      end
      ST_MEM_WR: begin
        mem_we   = 1'b1;
        iord_sel = 1'b1;
      end
      ST_BRANCH: begin
        alu_a_sel  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src_sel = PCSRC_ALUOUT;
        pc_we      = zero;
      end
      ST_JUMP: begin
        pc_src_sel = PCSRC_JUMP;
        pc_we      = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: expected output vectors are queued as each
// cycle's stimulus is driven and popped when that cycle's outputs are sampled.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       iord_sel;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic [1:0] pc_src_sel;
    logic       reg_we;
    logic       wb_sel;
    logic       reg_dst_sel;
    logic       halted;
    logic       mem_err;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ir_opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_we, ir_we, mem_re, mem_we, iord_sel, alu_a_sel;
  logic [1:0] alu_b_sel, alu_op, pc_src_sel;
  logic       reg_we, wb_sel, reg_dst_sel, halted, mem_err;

  ov_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  mc_control_fsm #(
    .OPCODE_W   (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_opcode  (ir_opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .iord_sel   (iord_sel),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .alu_op     (alu_op),
    .pc_src_sel (pc_src_sel),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .reg_dst_sel(reg_dst_sel),
    .halted     (halted),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, written straight from the state descriptions.
  function automatic ov_t e_idle();
    ov_t o = '0;
    return o;
  endfunction

  function automatic ov_t e_fetch(input logic rdy);
    ov_t o = '0;
    o.mem_re = 1'b1; o.ir_we = rdy; o.pc_we = rdy; o.alu_b_sel = 2'd1;
    return o;
  endfunction

  function automatic ov_t e_decode();
    ov_t o = '0;
    o.alu_b_sel = 2'd2;
    return o;
  endfunction

  function automatic ov_t e_exec_r(input logic [1:0] aop);
    ov_t o = '0;
    o.alu_a_sel = 1'b1; o.alu_op = aop;
    return o;
  endfunction

  function automatic ov_t e_imm_add();
    ov_t o = '0;
    o.alu_a_sel = 1'b1; o.alu_b_sel = 2'd2;
    return o;
  endfunction

  function automatic ov_t e_alu_wb(input logic dst);
    ov_t o = '0;
    o.reg_we = 1'b1; o.reg_dst_sel = dst;
    return o;
  endfunction

  function automatic ov_t e_mem_rd();
    ov_t o = '0;
    o.mem_re = 1'b1; o.iord_sel = 1'b1;
    return o;
  endfunction

  function automatic ov_t e_mem_wb();
    ov_t o = '0;
    o.reg_we = 1'b1; o.wb_sel = 1'b1; o.reg_dst_sel = 1'b1;
    return o;
  endfunction

  function automatic ov_t e_mem_wr();
    ov_t o = '0;
    o.mem_we = 1'b1; o.iord_sel = 1'b1;
    return o;
  endfunction

  function automatic ov_t e_branch(input logic z);
    ov_t o = '0;
    o.alu_a_sel = 1'b1; o.alu_op = 2'd1; o.pc_src_sel = 2'd1; o.pc_we = z;
    return o;
  endfunction

  function automatic ov_t e_jump();
    ov_t o = '0;
    o.pc_src_sel = 2'd2; o.pc_we = 1'b1;
    return o;
  endfunction

  function automatic ov_t e_halt(input logic err);
    ov_t o = '0;
    o.halted = 1'b1; o.mem_err = err;
    return o;
  endfunction

  task automatic check_output(input string tag);
    ov_t got;
    ov_t want;
    got = '{pc_we, ir_we, mem_re, mem_we, iord_sel, alu_a_sel, alu_b_sel, alu_op,
            pc_src_sel, reg_we, wb_sel, reg_dst_sel, halted, mem_err};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Called at a falling edge: drive this cycle's inputs, sample, step one cycle.
  task automatic apply_stimulus(input string tag, input logic [3:0] opc,
                                input logic rdy, input logic z, input ov_t exp);
    ir_opcode = opc;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(exp);
    #1;
    check_output(tag);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    rst_n = 1'b0; ir_opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(e_idle());
    check_output("reset_hold");
    rst_n = 1'b1;
    apply_stimulus("rst_idle", OP_ADD, 1'b1, 1'b0, e_idle());

    // ADD with zero-wait memory: 4 cycles
    apply_stimulus("add_fetch",  OP_ADD, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("add_decode", OP_ADD, 1'b1, 1'b0, e_decode());
    apply_stimulus("add_exec",   OP_ADD, 1'b1, 1'b0, e_exec_r(2'd0));
    apply_stimulus("add_wb",     OP_ADD, 1'b1, 1'b0, e_alu_wb(1'b0));

    // OR, with a two-cycle stalled fetch first
    apply_stimulus("or_fetch_st0", OP_OR, 1'b0, 1'b0, e_fetch(1'b0));
    apply_stimulus("or_fetch_st1", OP_OR, 1'b0, 1'b0, e_fetch(1'b0));
    apply_stimulus("or_fetch",     OP_OR, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("or_decode",    OP_OR, 1'b1, 1'b0, e_decode());
    apply_stimulus("or_exec",      OP_OR, 1'b1, 1'b0, e_exec_r(2'd3));
    apply_stimulus("or_wb",        OP_OR, 1'b1, 1'b0, e_alu_wb(1'b0));

    // ADDI writes to rt
    apply_stimulus("addi_fetch",  OP_ADDI, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("addi_decode", OP_ADDI, 1'b1, 1'b0, e_decode());
    apply_stimulus("addi_exec",   OP_ADDI, 1'b1, 1'b0, e_imm_add());
    apply_stimulus("addi_wb",     OP_ADDI, 1'b1, 1'b0, e_alu_wb(1'b1));

    // LW with three stalled cycles in MEM_RD
    apply_stimulus("lw_fetch",  OP_LW, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("lw_decode", OP_LW, 1'b1, 1'b0, e_decode());
    apply_stimulus("lw_addr",   OP_LW, 1'b1, 1'b0, e_imm_add());
    for (int i = 0; i < 3; i++)
      apply_stimulus("lw_rd_wait", OP_LW, 1'b0, 1'b0, e_mem_rd());
    apply_stimulus("lw_rd_done", OP_LW, 1'b1, 1'b0, e_mem_rd());
    apply_stimulus("lw_wb",      OP_LW, 1'b1, 1'b0, e_mem_wb());

    // SW zero-wait: 4 cycles
    apply_stimulus("sw_fetch",  OP_SW, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("sw_decode", OP_SW, 1'b1, 1'b0, e_decode());
    apply_stimulus("sw_addr",   OP_SW, 1'b1, 1'b0, e_imm_add());
    apply_stimulus("sw_wr",     OP_SW, 1'b1, 1'b0, e_mem_wr());

    // BEQ taken then not taken
    apply_stimulus("beq1_fetch",  OP_BEQ, 1'b1, 1'b1, e_fetch(1'b1));
    apply_stimulus("beq1_decode", OP_BEQ, 1'b1, 1'b1, e_decode());
    apply_stimulus("beq1_branch", OP_BEQ, 1'b1, 1'b1, e_branch(1'b1));
    apply_stimulus("beq0_fetch",  OP_BEQ, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("beq0_decode", OP_BEQ, 1'b1, 1'b0, e_decode());
    apply_stimulus("beq0_branch", OP_BEQ, 1'b1, 1'b0, e_branch(1'b0));

    // JMP, then illegal opcode 9 behaves as a NOP
    apply_stimulus("jmp_fetch",  OP_JMP, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("jmp_decode", OP_JMP, 1'b1, 1'b0, e_decode());
    apply_stimulus("jmp_jump",   OP_JMP, 1'b1, 1'b0, e_jump());
    apply_stimulus("ill_fetch",  4'd9,   1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("ill_decode", 4'd9,   1'b1, 1'b0, e_decode());

    // Asynchronous reset in the middle of a stalled store
    apply_stimulus("rst_fetch",  OP_SW, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("rst_decode", OP_SW, 1'b1, 1'b0, e_decode());
    apply_stimulus("rst_addr",   OP_SW, 1'b1, 1'b0, e_imm_add());
    mem_ready = 1'b0;
    exp_q.push_back(e_mem_wr());
    #1;
    check_output("rst_wr_before");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(e_idle());
    check_output("rst_async_drop");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("rst_idle2", OP_HLT, 1'b1, 1'b0, e_idle());

    // HLT instruction parks the FSM
    apply_stimulus("hlt_fetch",  OP_HLT, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("hlt_decode", OP_HLT, 1'b1, 1'b0, e_decode());
    apply_stimulus("hlt_halt0",  OP_ADD, 1'b1, 1'b0, e_halt(1'b0));
    apply_stimulus("hlt_halt1",  OP_ADD, 1'b1, 1'b0, e_halt(1'b0));

    // SW with mem_ready stuck low times out into HALT with mem_err
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus("to_fetch",  OP_SW, 1'b1, 1'b0, e_fetch(1'b1));
    apply_stimulus("to_decode", OP_SW, 1'b1, 1'b0, e_decode());
    apply_stimulus("to_addr",   OP_SW, 1'b1, 1'b0, e_imm_add());
    for (int i = 0; i < 4; i++)
      apply_stimulus("to_wr_wait", OP_SW, 1'b0, 1'b0, e_mem_wr());
    waited = 0;
    while (!halted && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    apply_stimulus("to_halt",    OP_SW, 1'b0, 1'b0, e_halt(1'b1));
    apply_stimulus("to_stay",    OP_ADD, 1'b1, 1'b0, e_halt(1'b1));
    rst_n = 1'b0;
    #1;
    exp_q.push_back(e_idle());
    check_output("to_reset_clears_err");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("to_idle", OP_ADD, 1'b1, 1'b0, e_idle());
    apply_stimulus("to_refetch", OP_ADD, 1'b1, 1'b0, e_fetch(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
